// File: rtl/stream_mux_rr.sv
// +--------------------------------------------------------------------------+
// | stream_mux_rr : N-to-1 valid/ready stream mux, round-robin or fixed prio |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module stream_mux_rr #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  parameter  int RR = 1,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [N*W-1:0] in_data_i,
  input  logic [N-1:0]   in_valid_i,
  output logic [N-1:0]   in_ready_o,
  input  logic [N-1:0]   ch_en_i,
  output logic [W-1:0]   out_data_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [SW-1:0]  out_sel_o
);

  logic [N-1:0]  w_req;
  logic          w_load;
  logic          w_found;
  logic [SW-1:0] w_grant;
  logic [SW:0]   w_idx;
  logic [W-1:0]  w_grant_data;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_sel_q,   out_sel_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  assign w_req  = in_valid_i & ch_en_i;
  assign w_load = ~out_valid_q | out_ready_i;

  // Search upward from ptr with wrap; with RR=0 ptr stays 0, giving lowest-index priority.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, ptr_q} + (SW+1)'(k);
      if (w_idx >= (SW+1)'(N)) begin
        w_idx = w_idx - (SW+1)'(N);
      end
      if (!w_found && w_req[w_idx[SW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[SW-1:0];
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SW'(i)) begin
        w_grant_data = in_data_i[i*W +: W];
      end
    end
  end

  assign in_ready_o = (w_load && w_found && !reset_i) ? (N'(1) << w_grant) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (w_load) begin
      out_valid_d = w_found;
      if (w_found) begin
        out_data_d = w_grant_data;
        out_sel_d  = w_grant;
        if (RR != 0) begin
          ptr_d = (w_grant == SW'(N-1)) ? '0 : w_grant + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// +--------------------------------------------------------------------------+
// | tb_stream_mux_rr : directed bench for stream_mux_rr (RR4, FP4, RR3)      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a_*: N=4 round-robin, b_*: N=4 fixed priority, c_*: N=3 round-robin
  logic [31:0] a_data;  logic [3:0] a_valid, a_en, a_rdy;  logic a_ordy, a_ovalid;
  logic [7:0]  a_odata; logic [1:0] a_osel;
  logic [31:0] b_data;  logic [3:0] b_valid, b_en, b_rdy;  logic b_ordy, b_ovalid;
  logic [7:0]  b_odata; logic [1:0] b_osel;
  logic [23:0] c_data;  logic [2:0] c_valid, c_en, c_rdy;  logic c_ordy, c_ovalid;
  logic [7:0]  c_odata; logic [1:0] c_osel;

  stream_mux_rr #(.N(4), .W(8), .RR(1)) u_rr4 (
    .clk_i(clk), .reset_i(reset), .in_data_i(a_data), .in_valid_i(a_valid),
    .in_ready_o(a_rdy), .ch_en_i(a_en), .out_data_o(a_odata),
    .out_valid_o(a_ovalid), .out_ready_i(a_ordy), .out_sel_o(a_osel));

  stream_mux_rr #(.N(4), .W(8), .RR(0)) u_fp4 (
    .clk_i(clk), .reset_i(reset), .in_data_i(b_data), .in_valid_i(b_valid),
    .in_ready_o(b_rdy), .ch_en_i(b_en), .out_data_o(b_odata),
    .out_valid_o(b_ovalid), .out_ready_i(b_ordy), .out_sel_o(b_osel));

  stream_mux_rr #(.N(3), .W(8), .RR(1)) u_rr3 (
    .clk_i(clk), .reset_i(reset), .in_data_i(c_data), .in_valid_i(c_valid),
    .in_ready_o(c_rdy), .ch_en_i(c_en), .out_data_o(c_odata),
    .out_valid_o(c_ovalid), .out_ready_i(c_ordy), .out_sel_o(c_osel));

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    a_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a_valid = 4'b1111; a_en = 4'b1111; a_ordy = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", a_ovalid); end
    checks++; if (a_odata !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", a_odata); end
    checks++; if (a_osel !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", a_osel); end
    checks++; if (a_rdy !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", a_rdy); end
    reset = 1'b0; #1;
    checks++; if (a_rdy !== 4'b0001) begin errors++; $display("FAIL rst_rel_ready got %b want 0001", a_rdy); end
    @(posedge clk); #1;
    checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd0 || a_odata !== 8'hA0) begin
      errors++; $display("FAIL rst_first_beat got v%b s%0d d%h want v1 s0 dA0", a_ovalid, a_osel, a_odata); end
    @(posedge clk); #1;
    checks++; if (a_osel !== 2'd1) begin errors++; $display("FAIL rst_second_sel got %0d want 1", a_osel); end
    reset = 1'b1; #1;
    checks++; if (a_ovalid !== 1'b0 || a_rdy !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_stream got v%b r%b want v0 r0000", a_ovalid, a_rdy); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd0) begin
      errors++; $display("FAIL rst_restart got v%b s%0d want v1 s0", a_ovalid, a_osel); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp;
    logic [3:0] expr;
    a_valid = 4'b1111; a_en = 4'b1111; a_ordy = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp = 2'(k % 4);
      expr = 4'b0001 << exp;
      checks++; if (a_rdy !== expr) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, a_rdy, expr); end
      @(posedge clk); #1;
      checks++; if (a_ovalid !== 1'b1 || a_osel !== exp || a_odata !== (8'hA0 + 8'(exp))) begin
        errors++; $display("FAIL rr_beat[%0d] got v%b s%0d d%h want v1 s%0d d%h",
                           k, a_ovalid, a_osel, a_odata, exp, 8'hA0 + 8'(exp)); end
    end
  endtask

  task automatic test_fixed_priority;
    b_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    b_valid = 4'b1010; b_en = 4'b1111; b_ordy = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      checks++; if (b_rdy !== 4'b0010) begin errors++; $display("FAIL fp_ready[%0d] got %b want 0010", k, b_rdy); end
      @(posedge clk); #1;
      checks++; if (b_ovalid !== 1'b1 || b_osel !== 2'd1 || b_odata !== 8'hB1) begin
        errors++; $display("FAIL fp_beat[%0d] got v%b s%0d d%h want v1 s1 dB1", k, b_ovalid, b_osel, b_odata); end
    end
  endtask

  task automatic test_stall;
    a_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a_valid = 4'b1111; a_en = 4'b1111; a_ordy = 1'b1;
    do_reset();
    @(posedge clk); #1;
    a_ordy = 1'b0;
    a_data[7:0] = 8'h5A;
    #1;
    checks++; if (a_rdy !== 4'b0000) begin errors++; $display("FAIL stall_ready got %b want 0000", a_rdy); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd0 || a_odata !== 8'hA0 || a_rdy !== 4'b0000) begin
        errors++; $display("FAIL stall_hold[%0d] got v%b s%0d d%h r%b want v1 s0 dA0 r0000",
                           k, a_ovalid, a_osel, a_odata, a_rdy); end
    end
    a_data[7:0] = 8'hA0;
    a_ordy = 1'b1; #1;
    checks++; if (a_rdy !== 4'b0010) begin errors++; $display("FAIL stall_release_ready got %b want 0010", a_rdy); end
    @(posedge clk); #1;
    checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd1 || a_odata !== 8'hA1) begin
      errors++; $display("FAIL stall_next_beat got v%b s%0d d%h want v1 s1 dA1", a_ovalid, a_osel, a_odata); end
  endtask

  task automatic test_enable_mask;
    logic [1:0] seq [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [3:0] expr;
    a_valid = 4'b1111; a_en = 4'b0101; a_ordy = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      expr = 4'b0001 << seq[k];
      checks++; if (a_rdy !== expr) begin errors++; $display("FAIL en_ready[%0d] got %b want %b", k, a_rdy, expr); end
      @(posedge clk); #1;
      checks++; if (a_osel !== seq[k] || a_odata !== (8'hA0 + 8'(seq[k]))) begin
        errors++; $display("FAIL en_beat[%0d] got s%0d d%h want s%0d", k, a_osel, a_odata, seq[k]); end
    end
    // channel 2 already holds the output register; disabling it must not drop that beat
    a_ordy = 1'b0; a_en = 4'b0001;
    @(posedge clk); #1;
    checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd2 || a_odata !== 8'hA2) begin
      errors++; $display("FAIL en_held_beat got v%b s%0d d%h want v1 s2 dA2", a_ovalid, a_osel, a_odata); end
    a_ordy = 1'b1; #1;
    checks++; if (a_rdy !== 4'b0001) begin errors++; $display("FAIL en_only0_ready got %b want 0001", a_rdy); end
    @(posedge clk); #1;
    a_en = 4'b0101; #1;
    checks++; if (a_rdy !== 4'b0100) begin errors++; $display("FAIL en_reenable_ready got %b want 0100", a_rdy); end
    a_en = 4'b0001; #1;
    checks++; if (a_rdy !== 4'b0001) begin errors++; $display("FAIL en_same_cycle_ready got %b want 0001", a_rdy); end
    @(posedge clk); #1;
    checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd0) begin
      errors++; $display("FAIL en_only0_beat got v%b s%0d want v1 s0", a_ovalid, a_osel); end
  endtask

  task automatic test_nonpow2_idle;
    logic [1:0] exp;
    c_data = {8'hC2, 8'hC1, 8'hC0};
    c_valid = 3'b111; c_en = 3'b111; c_ordy = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp = 2'(k % 3);
      @(posedge clk); #1;
      checks++; if (c_ovalid !== 1'b1 || c_osel !== exp || c_odata !== (8'hC0 + 8'(exp))) begin
        errors++; $display("FAIL np2_beat[%0d] got v%b s%0d d%h want s%0d", k, c_ovalid, c_osel, c_odata, exp); end
    end
    c_valid = 3'b000; #1;
    checks++; if (c_rdy !== 3'b000) begin errors++; $display("FAIL idle_ready got %b want 000", c_rdy); end
    @(posedge clk); #1;
    checks++; if (c_ovalid !== 1'b0 || c_osel !== 2'd0 || c_odata !== 8'hC0) begin
      errors++; $display("FAIL idle_drop got v%b s%0d d%h want v0 s0 dC0", c_ovalid, c_osel, c_odata); end
    @(posedge clk); #1;
    c_valid = 3'b111; #1;
    checks++; if (c_rdy !== 3'b010) begin errors++; $display("FAIL idle_ptr_hold_ready got %b want 010", c_rdy); end
    @(posedge clk); #1;
    checks++; if (c_ovalid !== 1'b1 || c_osel !== 2'd1 || c_odata !== 8'hC1) begin
      errors++; $display("FAIL idle_resume got v%b s%0d d%h want v1 s1 dC1", c_ovalid, c_osel, c_odata); end
  endtask

  initial begin
    a_data = '0; a_valid = '0; a_en = '0; a_ordy = 1'b0;
    b_data = '0; b_valid = '0; b_en = '0; b_ordy = 1'b0;
    c_data = '0; c_valid = '0; c_en = '0; c_ordy = 1'b0;
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_stall();
    test_enable_mask();
    test_nonpow2_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
